wb_stage_pipe: RTL
==================

Name: wb_stage_pipe

Overview:
- Registered, parametrised writeback stage for the SCC core. Sits between the memory stage and the two register files (general and ROM/microcode).
- Selects the writeback source: ALU result, load data, clear, set, mov, movt or movf. Issues a one-cycle write strobe with address and data to the chosen file.
- Supports variable-latency data-memory loads through a valid/ready handshake, with a timeout.

Parameters:
- DATA_W, 32, datapath width; must be >= 2*IMM_W.
- IMM_W, 16, immediate width.
- ADDR_W, 5, register address width.
- FLAG_W, 4, flag vector width; zero-extended to DATA_W.
- LOAD_TIMEOUT, 15, maximum LOAD_WAIT cycles before abort; must be >= 1.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, memory stage presents an instruction.
- in_ready, out, 1, stage can accept this cycle.
- load_flag, in, 1, instruction is a load.
- clear_flag, in, 1, write all zeros.
- set_flag, in, 1, write all ones.
- imm_flag, in, 1, mov source is the immediate.
- rom_flag, in, 1, target is the ROM register file.
- mov_flag, in, 2, 0 = none, 1 = mov, 2 = movt, 3 = movf.
- dest_addr, in, ADDR_W, destination register.
- alu_result, in, DATA_W, ALU output.
- reg_in, in, DATA_W, source register value for mov.
- imm_in, in, IMM_W, instruction immediate.
- flags_in, in, FLAG_W, current flags.
- mem_rvalid, in, 1, load data valid.
- mem_rdata, in, DATA_W, load data.
- wr_en, out, 1, general register file write strobe.
- rom_wr_en, out, 1, ROM register file write strobe.
- wr_addr, out, ADDR_W, write address, shared by both files.
- wr_data, out, DATA_W, write data, shared by both files.
- load_err, out, 1, one-cycle pulse on load timeout.
- busy, out, 1, high while in LOAD_WAIT.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; timeout counter = 0.
  - wr_en, rom_wr_en, load_err = 0; wr_addr, wr_data = 0.
  - in_ready = 0 while rst=1.
- in_ready = (state==IDLE) && !rst. busy = (state==LOAD_WAIT).
- Accept = in_valid && in_ready. Without an accept, no strobe is issued the next cycle.
- Source select, mov_flag=0:
  - Priority is load > clear > set > ALU.
  - clear writes 0; set writes all ones.
- Source select, mov_flag=1: imm_flag=1 writes zero-extended imm_in; imm_flag=0 writes reg_in.
- Source select, mov_flag=2: writes imm_in in the top IMM_W bits, zeros below. Behaviour for DATA_W > 2*IMM_W is identical (imm in the MSBs).
- Source select, mov_flag=3: writes zero-extended flags_in.
- load_flag is ignored when mov_flag != 0.
- Non-load accept:
  - On the next rising edge, register wr_addr = dest_addr and wr_data = selected value.
  - Raise wr_en if rom_flag=0, otherwise rom_wr_en. Never raise both.
  - Latency is 1 cycle. Strobes last exactly 1 cycle unless another accept occurs, giving back-to-back throughput of 1 per cycle.
- Load accept (load_flag=1, mov_flag=0):
  - Capture dest_addr and rom_flag; go to LOAD_WAIT; clear the counter; no strobe.
  - mem_rvalid is sampled only in LOAD_WAIT. A response in the accept cycle is ignored.
- LOAD_WAIT, mem_rvalid=1:
  - Next edge: wr_data = mem_rdata, wr_addr = captured address, strobe the captured file, state = IDLE.
  - in_ready is high in the strobe cycle.
- LOAD_WAIT, mem_rvalid=0:
  - Counter increments.
  - When counter == LOAD_TIMEOUT-1 and mem_rvalid=0: next edge state = IDLE, load_err pulses 1 cycle, no write strobe.
  - A late mem_rvalid arriving in IDLE is ignored.
- Simultaneous mem_rvalid and the timeout edge: mem_rvalid wins; write occurs and load_err stays 0.
- Reset mid-load: immediate return to IDLE, no strobe, no load_err.

Test Plan:
- ALU writeback: reset, then accept alu_result=0x1234_5678, dest=7, rom_flag=0. Next cycle wr_en=1, wr_addr=7, wr_data=0x12345678, rom_wr_en=0. One cycle later wr_en=0.
- Immediate and flag moves: back-to-back accepts of mov imm 0xBEEF (rom_flag=1), movt 0xBEEF, movf flags=4'b1010, and clear+set together. Expected strobes on consecutive cycles:
  - rom_wr_en with 0x0000BEEF;
  - wr_en with 0xBEEF0000;
  - wr_en with 0x0000000A;
  - wr_en with 0x00000000 (clear beats set).
- Load, 3-cycle latency: accept load dest=3, in_ready drops, busy=1. mem_rvalid=1 with 0xCAFEF00D on the 3rd LOAD_WAIT cycle. Next cycle wr_en=1, wr_addr=3, wr_data=0xCAFEF00D, in_ready=1.
- Load timeout: LOAD_TIMEOUT=15, never assert mem_rvalid. Exactly 15 cycles after accept, load_err pulses 1 cycle with no strobe. A mem_rvalid one cycle later causes no write.
- Boundary: mem_rvalid on the final counter cycle gives a write and load_err=0. mem_rvalid in the accept cycle is ignored and the block keeps waiting.
- Async reset during LOAD_WAIT: all outputs go to 0 without waiting for a clock edge. After release in_ready=1, and a subsequent ALU accept writes normally.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects the writeback source and issues a one-cycle write strobe
// to the general or ROM register file, with variable-latency loads and a load timeout.
module wb_stage_pipe #(
  parameter int DATA_W       = 32,
  parameter int IMM_W        = 16,
  parameter int ADDR_W       = 5,
  parameter int FLAG_W       = 4,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_flag,
  input  logic              clear_flag,
  input  logic              set_flag,
  input  logic              imm_flag,
  input  logic              rom_flag,
  input  logic [1:0]        mov_flag,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] reg_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_en,
  output logic              rom_wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              load_err,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [ADDR_W-1:0]  load_addr;
  logic [ADDR_W-1:0]  load_addr_next;
  logic               load_rom;
  logic               load_rom_next;
  logic               wr_en_next;
  logic               rom_wr_en_next;
  logic               load_err_next;
  logic [ADDR_W-1:0]  wr_addr_next;
  logic [DATA_W-1:0]  wr_data_next;
  logic               accept;
  logic               is_load;

  function automatic logic [DATA_W-1:0] select_data(
    input logic [1:0]        mov,
    input logic              clr,
    input logic              set,
    input logic              imm_sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] rv,
    input logic [IMM_W-1:0]  imm,
    input logic [FLAG_W-1:0] flg
  );
    logic [DATA_W-1:0] d;
    case (mov)
      2'd0: begin
        if (clr) begin
          d = {DATA_W{1'b0}};
        end else if (set) begin
          d = {DATA_W{1'b1}};
        end else begin
          d = alu;
        end
      end
      2'd1: begin
        if (imm_sel) begin
          d = {{(DATA_W-IMM_W){1'b0}}, imm};
        end else begin
          d = rv;
        end
      end
      2'd2:    d = {imm, {(DATA_W-IMM_W){1'b0}}};
      2'd3:    d = {{(DATA_W-FLAG_W){1'b0}}, flg};
      default: d = {DATA_W{1'b0}};
    endcase
    return d;
  endfunction

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state == LOAD_WAIT);
  assign accept   = in_valid && in_ready;
  assign is_load  = load_flag && (mov_flag == 2'd0);

  // Next-state, timeout counter and next registered outputs.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    load_addr_next = load_addr;
    load_rom_next  = load_rom;
    wr_en_next     = 1'b0;
    rom_wr_en_next = 1'b0;
    load_err_next  = 1'b0;
    wr_addr_next   = wr_addr;
    wr_data_next   = wr_data;
    case (state)
      IDLE: begin
        if (accept && is_load) begin
          state_next     = LOAD_WAIT;
          cnt_next       = {CNT_W{1'b0}};
          load_addr_next = dest_addr;
          load_rom_next  = rom_flag;
        end else if (accept) begin
          wr_addr_next   = dest_addr;
          wr_data_next   = select_data(mov_flag, clear_flag, set_flag, imm_flag,
                                       alu_result, reg_in, imm_in, flags_in);
          wr_en_next     = !rom_flag;
          rom_wr_en_next = rom_flag;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD_WAIT: begin
        // A response on the final counter cycle still completes the load.
        if (mem_rvalid) begin
          state_next     = IDLE;
          wr_addr_next   = load_addr;
          wr_data_next   = mem_rdata;
          wr_en_next     = !load_rom;
          rom_wr_en_next = load_rom;
        end else if (cnt == CNT_LAST) begin
          state_next    = IDLE;
          load_err_next = 1'b1;
        end else begin
          cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, load context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= {CNT_W{1'b0}};
      load_addr <= {ADDR_W{1'b0}};
      load_rom  <= 1'b0;
      wr_en     <= 1'b0;
      rom_wr_en <= 1'b0;
      load_err  <= 1'b0;
      wr_addr   <= {ADDR_W{1'b0}};
      wr_data   <= {DATA_W{1'b0}};
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      load_addr <= load_addr_next;
      load_rom  <= load_rom_next;
      wr_en     <= wr_en_next;
      rom_wr_en <= rom_wr_en_next;
      load_err  <= load_err_next;
      wr_addr   <= wr_addr_next;
      wr_data   <= wr_data_next;
    end
  end

endmodule
